// File: rtl/frsim_edge_capture.sv
// Timestamped edge recorder: queues {level, timestamp} for every transition of sig_in.
// Optional drop counter port enabled by defining FRSIM_EDGE_CAPTURE_DROP_CNT_EN.
module frsim_edge_capture #(
  parameter int unsigned TS_W = 32,
  parameter int unsigned AW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            sig_in,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic            evt_level,
  output logic [TS_W-1:0] evt_time,
  output logic [AW:0]     fifo_level,
  output logic            overflow
`ifdef FRSIM_EDGE_CAPTURE_DROP_CNT_EN
  ,
  output logic [15:0]     drop_cnt
`endif
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned EW    = TS_W + 1;

  logic [TS_W-1:0] r_ts_cnt;
  logic            r_sig_q;
  logic            r_sig_qq;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [EW-1:0]   r_mem [DEPTH];

  logic            w_edge;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [PW-1:0]   w_wr_nxt;
  logic [PW-1:0]   w_rd_nxt;
  logic [EW-1:0]   w_entry;
  logic [EW-1:0]   w_head_nxt;

  // Push/pop decisions and the head value the outputs will show next cycle.
  always_comb begin
    w_edge     = r_sig_q ^ r_sig_qq;
    w_empty    = (r_wr_ptr == r_rd_ptr);
    w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop      = !w_empty && evt_ready;
    w_push     = w_edge && en && (!w_full || w_pop);
    w_drop     = w_edge && en && w_full && !w_pop;
    w_wr_nxt   = r_wr_ptr + PW'(w_push);
    w_rd_nxt   = r_rd_ptr + PW'(w_pop);
    w_entry    = {r_sig_q, r_ts_cnt};
    w_head_nxt = '0;
    if (w_wr_nxt != w_rd_nxt) begin
      // Head slot is the one being written this cycle only when the queue was drained to it.
      if (w_rd_nxt == r_wr_ptr) w_head_nxt = w_entry;
      else                      w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts_cnt   <= '0;
      r_sig_q    <= 1'b0;
      r_sig_qq   <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      evt_valid  <= 1'b0;
      evt_level  <= 1'b0;
      evt_time   <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      r_ts_cnt   <= r_ts_cnt + TS_W'(1);
      r_sig_q    <= sig_in;
      r_sig_qq   <= r_sig_q;
      r_wr_ptr   <= w_wr_nxt;
      r_rd_ptr   <= w_rd_nxt;
      evt_valid  <= (w_wr_nxt != w_rd_nxt);
      evt_level  <= w_head_nxt[EW-1];
      evt_time   <= w_head_nxt[TS_W-1:0];
      fifo_level <= w_wr_nxt - w_rd_nxt;
      if (w_drop) overflow <= 1'b1;
    end
  end

  // Storage array, no reset needed: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
  end

`ifdef FRSIM_EDGE_CAPTURE_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                drop_cnt <= '0;
    else if (w_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_frsim_edge_capture.sv
// Randomized bench for frsim_edge_capture against a queue-based model of the edge log.
module tb_frsim_edge_capture;

  localparam int unsigned TS_W  = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 2 ** AW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            sig_in = 1'b0;
  logic            evt_ready = 1'b0;
  logic            evt_valid;
  logic            evt_level;
  logic [TS_W-1:0] evt_time;
  logic [AW:0]     fifo_level;
  logic            overflow;
`ifdef FRSIM_EDGE_CAPTURE_DROP_CNT_EN
  logic [15:0]     drop_cnt;
`endif

  frsim_edge_capture #(.TS_W(TS_W), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sig_in     (sig_in),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_level  (evt_level),
    .evt_time   (evt_time),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef FRSIM_EDGE_CAPTURE_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: event log as a queue of {level, time}, plus the time of the current cycle.
  logic [TS_W:0] m_q[$];
  int unsigned   m_ts = 0;
  bit            m_last_sample = 1'b0;
  bit            m_edge_pending = 1'b0;
  bit            m_edge_level = 1'b0;
  bit            m_ovf = 1'b0;
  int unsigned   m_drop = 0;
  bit            cur_sig = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clock(input bit r, input bit e, input bit s, input bit rd);
    int  size_pre;
    bit  pop;
    if (r) begin
      m_q.delete();
      m_ts = 0; m_last_sample = 0; m_edge_pending = 0; m_edge_level = 0;
      m_ovf = 0; m_drop = 0;
      return;
    end
    size_pre = m_q.size();
    pop = (size_pre > 0) && rd;
    if (pop) void'(m_q.pop_front());
    if (m_edge_pending && e) begin
      if (size_pre < DEPTH || pop) m_q.push_back({m_edge_level, TS_W'(m_ts)});
      else begin
        m_ovf = 1'b1;
        if (m_drop < 16'hFFFF) m_drop++;
      end
    end
    // A sample that differs from the previous one makes the following cycle an edge cycle.
    m_edge_pending = (s != m_last_sample);
    m_edge_level   = s;
    m_last_sample  = s;
    m_ts = (m_ts + 1) % (2 ** TS_W);
  endtask

  task automatic compare_all();
    logic [TS_W:0] head;
    head = (m_q.size() > 0) ? m_q[0] : '0;
    check("valid", 32'(evt_valid), 32'(m_q.size() != 0));
    check("level_out", 32'(fifo_level), 32'(m_q.size()));
    check("evt_level", 32'(evt_level), 32'(head[TS_W]));
    check("evt_time", 32'(evt_time), 32'(head[TS_W-1:0]));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef FRSIM_EDGE_CAPTURE_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), m_drop);
`endif
  endtask

  task automatic step(input bit r, input bit e, input bit s, input bit rd);
    rst = r; en = e; sig_in = s; evt_ready = rd;
    @(posedge clk);
    model_clock(r, e, s, rd);
    #1;
    compare_all();
  endtask

  initial begin
    int rdy_pct;
    int tog_pct;
    int en_pct;
    // Two reset cycles; outputs must read zero.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);

    // Rising edge sampled at ts 4 -> recorded with ts 5, visible from ts 6.
    while (m_ts <= 7) step(0, 1, (m_ts >= 4), 0);
    check("t1_time", 32'(evt_time), 32'd5);
    check("t1_lvl", 32'(evt_level), 32'd1);
    check("t1_fill", 32'(fifo_level), 32'd1);
    cur_sig = 1'b1;

    // Toggle every 2 cycles with no pops: fills the queue and overflows.
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) cur_sig = ~cur_sig;
      step(0, 1, cur_sig, 0);
    end
    check("t2_full", 32'(fifo_level), 32'(DEPTH));
    check("t2_ovf", 32'(overflow), 32'd1);

    // Continuous drain with the signal held.
    for (int i = 0; i < 12; i++) step(0, 1, cur_sig, 1);
    check("t3_empty", 32'(evt_valid), 32'd0);
    check("t3_time0", 32'(evt_time), 32'd0);

    // Reset mid-operation with entries queued and ready high.
    for (int i = 0; i < 10; i++) begin
      cur_sig = ~cur_sig;
      step(0, 1, cur_sig, 0);
    end
    step(1, 1, cur_sig, 1);
    check("t6_valid", 32'(evt_valid), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    cur_sig = 1'b0;

    // Randomized phases of readiness, toggle density and enable.
    for (int ph = 0; ph < 20; ph++) begin
      case ($urandom_range(0, 3))
        0: rdy_pct = 0;
        1: rdy_pct = 30;
        2: rdy_pct = 70;
        default: rdy_pct = 100;
      endcase
      tog_pct = int'($urandom_range(10, 90));
      en_pct  = (ph % 5 == 3) ? 0 : 85;
      for (int i = 0; i < 80; i++) begin
        if (int'($urandom_range(0, 99)) < tog_pct) cur_sig = ~cur_sig;
        step(($urandom_range(0, 299) == 0),
             (int'($urandom_range(0, 99)) < en_pct),
             cur_sig,
             (int'($urandom_range(0, 99)) < rdy_pct));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
